// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO-to-stream drain path: occupancy encoding, buffer depth,
// and the valid/ready handshake pair used by stream stages.
package fifo_stream_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic vld;
        logic rdy;
    } stream_hs_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output buffer with occupancy state; head entry drives the stream.
// Latency: a write appears on rd_dat the edge after wr_vld; rd_rdy=0 holds the head stable.
module stream_skid_buf
    import fifo_stream_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_vld,
    input  logic [width-1:0] wr_dat,
    output logic             rd_vld,
    output logic [width-1:0] rd_dat,
    input  logic             rd_rdy,
    output occ_t             occ
);

    occ_t             occ_nxt;
    logic [width-1:0] buf0_q;
    logic [width-1:0] buf1_q;
    logic [width-1:0] buf0_nxt;
    logic [width-1:0] buf1_nxt;
    logic             pop;
    logic [1:0]       slot;

    assign rd_vld = (occ != OCC_EMPTY);
    assign rd_dat = buf0_q;
    assign pop    = rd_vld & rd_rdy;
    // A capture lands behind whatever survives this edge's pop.
    assign slot   = 2'(occ) - {1'b0, pop};

    always_comb begin
        occ_nxt  = occ;
        buf0_nxt = buf0_q;
        buf1_nxt = buf1_q;
        case (occ)
            OCC_EMPTY: if (wr_vld) occ_nxt = OCC_ONE;
            OCC_ONE: begin
                if (wr_vld && !pop)      occ_nxt = OCC_TWO;
                else if (!wr_vld && pop) occ_nxt = OCC_EMPTY;
            end
            OCC_TWO:   if (pop && !wr_vld) occ_nxt = OCC_ONE;
            default:   occ_nxt = OCC_EMPTY;
        endcase
        if (pop) buf0_nxt = buf1_q;
        if (wr_vld) begin
            if (slot == 2'd0) buf0_nxt = wr_dat;
            else              buf1_nxt = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            occ    <= OCC_EMPTY;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            occ    <= occ_nxt;
            buf0_q <= buf0_nxt;
            buf1_q <= buf1_nxt;
        end
    end

endmodule

// File: rtl/fifo_stream_drain.sv
// Pops a 1-cycle-latency sync FIFO into a valid/ready stream at up to 1 word/cycle.
// Latency: 2 edges from accepted pop to m_valid; m_ready=0 stops pops once 2 words are held.
// Optional word_cnt delivered-word counter when FIFO_DRAIN_STATS_EN is defined.
module fifo_stream_drain
    import fifo_stream_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [width-1:0] fifo_data_out,
    input  logic             fifo_empty,
    output logic             fifo_read,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]      word_cnt
`endif
);

    occ_t       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] credit;
    stream_hs_t m_hs;

    assign m_hs   = '{vld: m_valid, rdy: m_ready};
    assign pop    = m_hs.vld & m_hs.rdy;
    // Words already requested but not yet captured still consume buffer space.
    assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_read = rst_ & ~fifo_empty & (credit < 3'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) inflight <= 1'b0;
        else       inflight <= fifo_read & ~fifo_empty;
    end

    stream_skid_buf #(.width(width)) u_skid (
        .clk    (clk),
        .rst_   (rst_),
        .wr_vld (inflight),
        .wr_dat (fifo_data_out),
        .rd_vld (m_valid),
        .rd_dat (m_data),
        .rd_rdy (m_ready),
        .occ    (occ)
    );

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)    word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural sync FIFO feeding the DUT, scoreboard on the stream side.
// Define FIFO_DRAIN_STATS_EN to also cover word_cnt.
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [15:0] fifo_data_out = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_read;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] word_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          pops = 0;
    int          outs = 0;
    int          outs_e = 0;
    int          pop_cyc[512];
    int          out_cyc[512];
    logic        bound_en = 1'b0;

    fifo_stream_drain #(.width(16)) dut (
        .clk           (clk),
        .rst_          (rst_),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_read     (fifo_read),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .word_cnt      (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sync FIFO model: pop accepted at the edge, data valid the following cycle.
    always @(posedge clk) begin
        if (fifo_read && !fifo_empty && fifo_q.size() > 0) begin
            fifo_data_out <= fifo_q.pop_front();
            pop_cyc[pops] = cyc;
            pops++;
        end
        if (m_valid && m_ready) outs_e++;
        fifo_empty <= (fifo_q.size() == 0);
        cyc++;
    end

    // Stream-side scoreboard, sampled half a cycle before the accepting edge.
    always @(negedge clk) begin
        if (rst_ && m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("sb_extra", {16'h0, m_data}, 32'hFFFF_FFFF);
            else                   chk("sb_data", {16'h0, m_data}, {16'h0, exp_q.pop_front()});
            out_cyc[outs] = cyc;
            outs++;
        end
        if (bound_en) chk("occ_bound", 32'(pops - outs_e <= 2), 32'd1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + 16'(i));
            exp_q.push_back(base + 16'(i));
        end
    endtask

    task automatic do_reset();
        rst_ = 1'b0;
        tick(2);
        rst_ = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && fifo_q.size() == 0 && fifo_empty && !m_valid) && n < 200) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int p0, o0, n;

        // 1: reset values, then a single word
        m_ready = 1'b1;
        load(1, 16'h0007);
        tick(3);
        @(negedge clk);
        chk("rst_fifo_read", 32'(fifo_read), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        p0 = pops; o0 = outs;
        tick(1);
        rst_ = 1'b1;
        @(negedge clk);
        chk("t1_read_hi", 32'(fifo_read), 32'd1);
        @(negedge clk);
        chk("t1_read_lo", 32'(fifo_read), 32'd0);
        chk("t1_valid_e1", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid_e2", 32'(m_valid), 32'd1);
        chk("t1_data", 32'(m_data), 32'h7);
        tick(1);
        wait_drain("t1_drain");
        chk("t1_pops", 32'(pops - p0), 32'd1);
        chk("t1_latency", 32'(out_cyc[o0] - pop_cyc[p0]), 32'd2);

        // 2: 16-word burst at full rate
        do_reset();
        p0 = pops; o0 = outs;
        load(16, 16'h0000);
        wait_drain("t2_drain");
        chk("t2_pops", 32'(pops - p0), 32'd16);
        chk("t2_outs", 32'(outs - o0), 32'd16);
        chk("t2_read_run", 32'(pop_cyc[p0+15] - pop_cyc[p0]), 32'd15);
        chk("t2_out_run", 32'(out_cyc[o0+15] - out_cyc[o0]), 32'd15);
        chk("t2_latency", 32'(out_cyc[o0] - pop_cyc[p0]), 32'd2);
`ifdef FIFO_DRAIN_STATS_EN
        chk("t6_word_cnt", word_cnt, 32'd16);
`endif

        // 3: backpressure holds two words and stops popping
        do_reset();
        m_ready = 1'b0;
        p0 = pops; o0 = outs;
        load(5, 16'h0100);
        tick(8);
        @(negedge clk);
        chk("t3_pops_held", 32'(pops - p0), 32'd2);
        chk("t3_valid", 32'(m_valid), 32'd1);
        chk("t3_head", 32'(m_data), 32'h100);
        chk("t3_read_lo", 32'(fifo_read), 32'd0);
        tick(3);
        @(negedge clk);
        chk("t3_head_stable", 32'(m_data), 32'h100);
        chk("t3_pops_stable", 32'(pops - p0), 32'd2);
        tick(1);
        m_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_outs", 32'(outs - o0), 32'd5);

        // 4: alternating m_ready
        do_reset();
        o0 = outs;
        bound_en = 1'b1;
        load(10, 16'h0200);
        for (int i = 0; i < 40; i++) begin
            m_ready = ~m_ready;
            tick(1);
        end
        bound_en = 1'b0;
        m_ready = 1'b1;
        wait_drain("t4_drain");
        chk("t4_outs", 32'(outs - o0), 32'd10);

        // 5: asynchronous reset with a full credit window
        do_reset();
        m_ready = 1'b0;
        p0 = pops;
        load(6, 16'h0300);
        n = 0;
        while (pops - p0 != 2 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t5_reach", 32'(pops - p0), 32'd2);
        chk("t5_valid_pre", 32'(m_valid), 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        chk("t5_valid_async", 32'(m_valid), 32'd0);
        chk("t5_read_async", 32'(fifo_read), 32'd0);
        exp_q = fifo_q;
        tick(2);
        o0 = outs;
        rst_ = 1'b1;
        m_ready = 1'b1;
        wait_drain("t5_drain");
        chk("t5_outs", 32'(outs - o0), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
